// File: rtl/seg_code_conv_if.sv
// Handshake/result bundle between the calculator datapath (master) and the
// seven-segment converter (slave).
interface seg_code_conv_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      data;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [DIGITS*8-1:0]   code;

    modport master (output start, data, input busy, done, ovf, code);
    modport slave  (input start, data, output busy, done, ovf, code);
endinterface

// File: rtl/seg_code_conv.sv
// Binary to seven-segment converter using a one-bit-per-clock double-dabble engine.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_code_conv #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    seg_code_conv_if.slave bus
);
    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ENCODE = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [WIDTH-1:0]    bin_q,    bin_d;
    logic [BW-1:0]       bcd_q,    bcd_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic                sticky_q, sticky_d;
    logic [DIGITS*8-1:0] code_q,   code_d;
    logic                ovf_q,    ovf_d;
    logic                done_q,   done_d;

    logic [BW-1:0]       bcd_adj_s;
    logic [DIGITS*8-1:0] enc_s;
`ifdef SEG_BLANK_EN
    logic                lead_s;
`endif

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hfc;
            4'd1:    seg = 8'h60;
            4'd2:    seg = 8'hda;
            4'd3:    seg = 8'hf2;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'hb6;
            4'd6:    seg = 8'hbe;
            4'd7:    seg = 8'he0;
            4'd8:    seg = 8'hfe;
            4'd9:    seg = 8'hf6;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // Add-3 correction of every BCD nibble ahead of the shift.
    always_comb begin
        bcd_adj_s = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*k +: 4] = bcd_q[4*k +: 4];
            end
        end
    end

    // Segment encoding of the finished BCD value, scanned from the top digit down.
    always_comb begin
        enc_s = '0;
`ifdef SEG_BLANK_EN
        lead_s = 1'b1;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (sticky_q) begin
                enc_s[8*k +: 8] = 8'h02;
`ifdef SEG_BLANK_EN
            end else if (lead_s && (bcd_q[4*k +: 4] == 4'd0) && (k != 0)) begin
                enc_s[8*k +: 8] = 8'h00;
`endif
            end else begin
                enc_s[8*k +: 8] = seg_encode(bcd_q[4*k +: 4]);
            end
`ifdef SEG_BLANK_EN
            if (bcd_q[4*k +: 4] != 4'd0) begin
                lead_s = 1'b0;
            end else begin
                lead_s = lead_s;
            end
`endif
        end
    end

    // Next-state logic for the IDLE / SHIFT / ENCODE sequencer and datapath.
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        code_d   = code_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d    = bus.data;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A 1 leaving the top nibble means the value no longer fits in DIGITS digits.
                bcd_d    = {bcd_adj_s[BW-2:0], bin_q[WIDTH-1]};
                bin_d    = {bin_q[WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | bcd_adj_s[BW-1];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_ENCODE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_ENCODE: begin
                code_d  = enc_s;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            code_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.code = code_q;

endmodule

// File: tb/tb_seg_code_conv.sv
// Directed self-checking bench for seg_code_conv (12-bit/3-digit and 16-bit/5-digit builds).
module tb_seg_code_conv;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg_code_conv_if #(.WIDTH(12), .DIGITS(3)) bus_a ();
    seg_code_conv_if #(.WIDTH(16), .DIGITS(5)) bus_b ();

    seg_code_conv #(.WIDTH(12), .DIGITS(3)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    seg_code_conv #(.WIDTH(16), .DIGITS(5)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

`ifdef SEG_BLANK_EN
    localparam logic [23:0] EXP_7 = 24'h0000e0;
    localparam logic [23:0] EXP_0 = 24'h0000fc;
`else
    localparam logic [23:0] EXP_7 = 24'hfcfce0;
    localparam logic [23:0] EXP_0 = 24'hfcfcfc;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference segment code for values below 1000 (3 digits).
    function automatic logic [23:0] ref_code3(input int v);
        logic [7:0]  tbl [0:9];
        logic [23:0] r;
        int          dig [0:2];
        int          hi;
        tbl = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0, 8'hfe, 8'hf6};
        dig[0] = v % 10;
        dig[1] = (v / 10) % 10;
        dig[2] = (v / 100) % 10;
        hi = 0;
        for (int k = 0; k < 3; k++) if (dig[k] != 0) hi = k;
        r = 24'h0;
        for (int k = 0; k < 3; k++) begin
            r[8*k +: 8] = tbl[dig[k]];
`ifdef SEG_BLANK_EN
            if (k > hi) r[8*k +: 8] = 8'h00;
`endif
        end
        return r;
    endfunction

    task automatic convert_a(input string tag, input logic [11:0] d,
                             input logic [23:0] exp_code, input logic exp_ovf);
        int cyc;
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.data  = d;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.data  = 12'habc;
        check_eq({tag, "_busy"}, 64'(bus_a.busy), 64'd1);
        cyc = 0;
        while (!bus_a.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'd13);
        check_eq({tag, "_code"}, 64'(bus_a.code), 64'(exp_code));
        check_eq({tag, "_ovf"}, 64'(bus_a.ovf), 64'(exp_ovf));
        check_eq({tag, "_busy_at_done"}, 64'(bus_a.busy), 64'd0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(bus_a.done), 64'd0);
    endtask

    initial begin
        int         cyc;
        int         n_done;
        int         done_at [0:3];
        logic [11:0] vals [0:39];

        bus_a.start = 1'b0;
        bus_a.data  = 12'd0;
        bus_b.start = 1'b0;
        bus_b.data  = 16'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        check_eq("rst_busy", 64'(bus_a.busy), 64'd0);
        check_eq("rst_done", 64'(bus_a.done), 64'd0);
        check_eq("rst_ovf",  64'(bus_a.ovf),  64'd0);
        check_eq("rst_code", 64'(bus_a.code), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        convert_a("v305",  12'd305,  24'hf2fcb6, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("hold_code", 64'(bus_a.code), 64'h00f2fcb6);
        convert_a("v999",  12'd999,  24'hf6f6f6, 1'b0);
        convert_a("v1000", 12'd1000, 24'h020202, 1'b1);
        convert_a("v4095", 12'd4095, 24'h020202, 1'b1);
        convert_a("v7",    12'd7,    EXP_7,      1'b0);
        convert_a("v0",    12'd0,    EXP_0,      1'b0);

        // start held for 20 cycles with changing data: accepted at cycles 0 and 14
        n_done = 0;
        for (int j = 0; j < 40; j++) vals[j] = 12'(100 + 37 * j);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus_a.done) begin
                if (n_done < 4) done_at[n_done] = j;
                if (n_done == 0) check_eq("held_code0", 64'(bus_a.code), 64'(ref_code3(100)));
                if (n_done == 1) check_eq("held_code1", 64'(bus_a.code), 64'(ref_code3(100 + 37 * 14)));
                n_done++;
            end
            bus_a.start = (j < 20);
            bus_a.data  = vals[j];
        end
        bus_a.start = 1'b0;
        check_eq("held_count", 64'(n_done), 64'd2);
        check_eq("held_first", 64'(done_at[0]), 64'd14);
        check_eq("held_gap",   64'(done_at[1] - done_at[0]), 64'd14);

        // asynchronous reset mid-conversion after a value that left ovf set
        convert_a("v4095b", 12'd4095, 24'h020202, 1'b1);
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.data  = 12'd123;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        check_eq("arst_busy", 64'(bus_a.busy), 64'd0);
        check_eq("arst_done", 64'(bus_a.done), 64'd0);
        check_eq("arst_ovf",  64'(bus_a.ovf),  64'd0);
        check_eq("arst_code", 64'(bus_a.code), 64'd0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        cyc = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (bus_a.done) cyc++;
        end
        check_eq("arst_no_done", 64'(cyc), 64'd0);
        convert_a("v305b", 12'd305, 24'hf2fcb6, 1'b0);

        // 16-bit / 5-digit instance
        @(negedge clk);
        bus_b.start = 1'b1;
        bus_b.data  = 16'd65535;
        @(negedge clk);
        bus_b.start = 1'b0;
        bus_b.data  = 16'd0;
        cyc = 0;
        while (!bus_b.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("w16_latency", 64'(cyc), 64'd17);
        check_eq("w16_code", 64'(bus_b.code), 64'hbeb6b6f2b6);
        check_eq("w16_ovf",  64'(bus_b.ovf),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_code_conv.md
# seg_code_conv

Sequential, parametrised binary-to-seven-segment converter for the calculator display path. It accepts an unsigned binary value on a start/busy/done handshake and converts it to BCD with a shift-add-3 (double-dabble) engine, one bit per clock. It then encodes each digit into an 8-bit active-high segment code using the segment table shared by the display logic. Results are registered, and overflow (value ≥ 10^DIGITS) is flagged. It sits between the calculator datapath and the display scan driver.

## Interface
- WIDTH, 12, bit width of `data`; must be ≥ 4
- DIGITS, 3, number of decimal digits produced; must be ≥ 1
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request conversion; sampled only when `busy`=0
- data  in  WIDTH  unsigned binary value; latched on an accepted `start`
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when `code`/`ovf` update
- ovf  out  1  the last converted value was ≥ 10^DIGITS
- code  out  DIGITS*8  segment codes; digit 0 (ones) in [7:0], digit k in [8k+7:8k]

## Operation
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE:
  - When `start`=1, latch `data` into the shift register, clear the BCD register (DIGITS*4 bits), clear the sticky overflow, load the bit counter with WIDTH, then go to SHIFT.
  - When `start`=0, stay in IDLE.
- SHIFT, once per cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {BCD, binary} left by 1.
  - If the bit shifted out of the BCD MSB is 1, set sticky overflow.
  - Decrement the counter. After the WIDTH-th shift, go to ENCODE.
- ENCODE:
  - Map each nibble to a segment code: 0→fc, 1→60, 2→da, 3→f2, 4→66, 5→b6, 6→be, 7→e0, 8→fe, 9→f6, others→00.
  - If overflow is set, every digit is 8'h02 ("-") and `ovf`=1.
  - Register `code` and `ovf`, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `code` and `ovf` hold their values between `done` pulses.
- Zero-value input: digit 0 shows "0".

## Timing
- Reset values: `busy`=0, `done`=0, `ovf`=0, `code`=0 (all segments off), FSM=IDLE.
- Reset is asynchronous. Asserting it mid-conversion aborts the conversion immediately and forces the reset values. No `done` pulse follows.
- Cycle numbering: `start` is sampled high at edge N.
  - `busy`=1 from after edge N through the ENCODE cycle.
  - `code`, `ovf` and `done`=1 are valid after edge N+WIDTH+1.
  - `busy`=0 and `done`=0 after edge N+WIDTH+2.
- Latency: WIDTH+1 cycles from start edge to `done`. Throughput: one conversion per WIDTH+2 cycles.
- Back-to-back: a `start` sampled on the cycle `done` is high (state IDLE) is accepted.
- Overflow detection is exact for any WIDTH/DIGITS combination. The sticky bit catches any 1 lost off the BCD MSB.

## Configuration
- SEG_BLANK_EN defined: leading-zero blanking.
  - Applied in ENCODE, scanning from the most significant digit downward.
  - Every zero digit above the highest nonzero digit encodes as 8'h00.
  - Digit 0 is never blanked.
  - Not applied when `ovf`=1.
- SEG_BLANK_EN undefined: all digits are always encoded, including leading zeros.

## Test plan
- Reset, then `data`=305, `start` pulse (WIDTH=12, DIGITS=3) -> `done` exactly 13 cycles after the start edge; `code`=24'hf2fcb6, `ovf`=0.
- `data`=999 -> `code`=24'hf6f6f6. Then `data`=1000 -> `ovf`=1, `code`=24'h020202. Then `data`=4095 -> `ovf`=1.
- `data`=7 -> with SEG_BLANK_EN `code`=24'h0000e0; without it `code`=24'hfcfce0. `data`=0 -> 24'h0000fc / 24'hfcfcfc.
- `start` held high for 20 cycles with `data` changing -> only the values sampled in IDLE convert; `done` pulses every 14 cycles; results match those latched values.
- `rst` asserted asynchronously 5 cycles into a conversion -> `busy`, `done`, `ovf` and `code` go to 0 without waiting for a clock edge. A new start after release converts correctly.
- Parameter sweep WIDTH=16, DIGITS=5, `data`=65535 -> `code`=40'hbeb6b6f2b6, `ovf`=0, `done` after 17 cycles.
